// File: rtl/fp_accumulator.sv
// Streaming floating-point accumulator: sums a vector of fp_t terms plus a bias,
// applies optional ReLU, and presents the result over a valid/ready handshake.

package tiny_nn_pkg;
  // 16-bit float: 1 sign, 5 exponent (bias 15), 10 mantissa; exponent 0 means zero.
  typedef struct packed {
    logic       sgn;
    logic [4:0] exp;
    logic [9:0] man;
  } fp_t;

  localparam fp_t FPZero = '0;
endpackage

// Combinational float adder: truncating, zero-flushing, returns FPZero on exact cancellation.
module fp_add
  import tiny_nn_pkg::*;
(
  input  fp_t a,
  input  fp_t b,
  output fp_t sum
);
  fp_t         x;
  fp_t         y;
  logic [4:0]  d;
  logic [14:0] mx;
  logic [14:0] my;
  logic [14:0] s;
  logic [5:0]  e;
  logic [3:0]  lead;
  logic [3:0]  shift;

  always_comb begin
    // NOTE: every variable gets a default up front so no path through this block infers a latch.
    x     = a;
    y     = b;
    s     = '0;
    lead  = '0;
    sum   = FPZero;
    if ({b.exp, b.man} > {a.exp, a.man}) begin
      x = b;
      y = a;
    end
    d  = x.exp - y.exp;
    mx = {2'b01, x.man, 3'b000};
    my = {2'b01, y.man, 3'b000} >> d;
    e  = {1'b0, x.exp};
    if (x.sgn == y.sgn) begin
      s = mx + my;
      if (s[14]) begin
        s = s >> 1;
        e = e + 6'd1;
      end
    end else begin
      s = mx - my;
    end
    for (int i = 0; i < 14; i++) begin
      if (s[i]) lead = 4'(i);
    end
    shift = 4'd13 - lead;
    if (y.exp == '0) begin
      sum = (x.exp == '0) ? FPZero : x;
    end else if (s == '0) begin
      sum = FPZero;
    end else if (e <= {2'b00, shift}) begin
      sum = FPZero;
    end else begin
      s   = s << shift;
      e   = e - {2'b00, shift};
      sum = '{sgn: x.sgn, exp: e[4:0], man: s[12:3]};
    end
  end
endmodule

module fp_accumulator
  import tiny_nn_pkg::*;
#(
  parameter int CountWidth  = 8,
  parameter bit ReluOutZero = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  fp_t                   in_data_i,
  input  logic                  in_last_i,
  input  fp_t                   bias_i,
  input  logic                  relu_en_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output fp_t                   out_data_o,
  output logic [CountWidth-1:0] out_count_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e                state_q;
  state_e                state_d;
  fp_t                   acc_q;
  fp_t                   op_a;
  fp_t                   sum;
  fp_t                   result;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;
  logic                  beat;
  logic                  first_beat;

  assign beat       = in_valid_i && in_ready_o;
  assign first_beat = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign op_a       = first_beat ? bias_i : acc_q;
  assign count_d    = first_beat ? CountWidth'(1)
                    : (&count_q) ? count_q : count_q + 1'b1;
  assign result     = (relu_en_i && ReluOutZero && sum.sgn) ? FPZero : sum;

  fp_add u_add (
    .a  (op_a),
    .b  (in_data_i),
    .sum(sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: flops take non-blocking assignments so every register updates from pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: if (beat) state_d = in_last_i ? DONE : ACC;
      DONE: begin
        if (out_ready_i) begin
          if (beat) state_d = in_last_i ? DONE : ACC;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q != DONE) || out_ready_i;
    busy_o     = (state_q == ACC);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= FPZero;
      count_q     <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= FPZero;
      out_count_o <= '0;
    end else begin
      if (beat) begin
        acc_q   <= sum;
        count_q <= count_d;
      end
      // A last beat in the handshake cycle reloads the outputs instead of dropping valid.
      if (beat && in_last_i) begin
        out_valid_o <= 1'b1;
        out_data_o  <= result;
        out_count_o <= count_d;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: directed plan items plus randomized vectors
// checked every cycle against a real-arithmetic reference model.

module tb_fp_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model state (values as reals).
  real         cur_d = 0.0;
  real         cur_b = 0.0;
  real         m_sum = 0.0;
  int          m_cnt = 0;
  int          m_cnt_out = 0;
  bit          m_open = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] m_data = '0;
  bit          exp_ready;
  bit          consumed;
  bit          accept;

  fp_accumulator #(.CountWidth(8), .ReluOutZero(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .bias_i     (bias),
    .relu_en_i  (relu_en),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_count_o(out_count),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_fp(input real r);
    real  m;
    int   e;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input real d, input bit last, input real b, input bit relu);
    cur_d    = d;
    cur_b    = b;
    in_data  = to_fp(d);
    bias     = to_fp(b);
    in_last  = last;
    relu_en  = relu;
    in_valid = 1'b1;
  endtask

  // Present one term and hold it until accepted; backpressure is released after a few cycles.
  task automatic send(input real d, input bit last, input real b, input bit relu);
    bit ok;
    ok = 1'b0;
    set_in(d, last, b, relu);
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (i >= 2) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  // Cycle-level reference: which beats are accepted, what each vector sums to.
  always @(negedge clk) begin
    if (rst) begin
      m_open = 1'b0;
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      exp_ready = !m_pend || out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(m_pend));
      check("busy", 32'(busy), 32'(m_open));
      if (m_pend) begin
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_count", 32'(out_count), 32'(m_cnt_out));
      end
      consumed = m_pend && out_ready;
      accept   = in_valid && exp_ready;
      if (consumed) m_pend = 1'b0;
      if (accept) begin
        if (!m_open) begin
          m_sum = cur_b + cur_d;
          m_cnt = 1;
        end else begin
          m_sum = m_sum + cur_d;
          if (m_cnt < 255) m_cnt++;
        end
        if (in_last) begin
          m_open    = 1'b0;
          m_pend    = 1'b1;
          m_data    = (relu_en && m_sum < 0.0) ? 16'h0000 : to_fp(m_sum);
          m_cnt_out = m_cnt;
        end else begin
          m_open = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // 0.0 + 1.0 + 2.0 + 0.5 = 3.5
    out_ready = 1'b1;
    send(1.0, 1'b0, 0.0, 1'b0);
    check("t1_busy_after_first", 32'(busy), 32'd1);
    send(2.0, 1'b0, 0.0, 1'b0);
    send(0.5, 1'b1, 0.0, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h4300);
    check("t1_count", 32'(out_count), 32'd3);
    check("t1_busy_done", 32'(busy), 32'd0);

    // 1.0 + -3.0 without and with ReLU
    send(-3.0, 1'b1, 1.0, 1'b0);
    check("neg_data", 32'(out_data), 32'hC000);
    check("neg_count", 32'(out_count), 32'd1);
    send(-3.0, 1'b1, 1.0, 1'b1);
    check("relu_data", 32'(out_data), 32'h0000);
    check("relu_count", 32'(out_count), 32'd1);
    step();

    // Backpressure: result 6.0 held while the next vector's first term waits.
    out_ready = 1'b0;
    send(2.0, 1'b0, 1.0, 1'b0);
    send(3.0, 1'b1, 1.0, 1'b0);
    set_in(4.0, 1'b1, 0.5, 1'b0);
    repeat (5) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'h4600);
      check("bp_count", 32'(out_count), 32'd2);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_next_data", 32'(out_data), 32'h4480);
    check("bp_next_count", 32'(out_count), 32'd1);

    // Back-to-back single-term vectors.
    send(1.0, 1'b1, 0.0, 1'b0);
    check("b2b_1", 32'(out_data), 32'h3C00);
    send(2.0, 1'b1, 0.0, 1'b0);
    check("b2b_2", 32'(out_data), 32'h4000);
    send(4.0, 1'b1, 0.0, 1'b0);
    check("b2b_4", 32'(out_data), 32'h4400);
    check("b2b_valid", 32'(out_valid), 32'd1);

    // Exact cancellation.
    send(2.0, 1'b0, 0.0, 1'b0);
    send(-2.0, 1'b1, 0.0, 1'b0);
    check("cancel_data", 32'(out_data), 32'h0000);
    check("cancel_count", 32'(out_count), 32'd2);

    // Counter saturation.
    for (int i = 0; i < 300; i++) send(0.0, i == 299, 0.0, 1'b0);
    check("sat_count", 32'(out_count), 32'd255);
    check("sat_data", 32'(out_data), 32'h0000);
    step();

    // Reset mid-vector discards it.
    send(1.0, 1'b0, 0.0, 1'b0);
    send(1.0, 1'b0, 0.0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("rst_mid_valid", 32'(out_valid), 32'd0);
    end
    send(1.25, 1'b1, 0.5, 1'b0);
    check("rst_mid_next", 32'(out_data), 32'h3F00);
    check("rst_mid_count", 32'(out_count), 32'd1);

    // Randomized vectors with gaps and backpressure.
    for (int v = 0; v < 40; v++) begin
      int  len;
      real b;
      bit  relu;
      len  = $urandom_range(1, 8);
      b    = real'($urandom_range(0, 64)) / 4.0 - 8.0;
      relu = $urandom_range(0, 1);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid  = 1'b0;
          out_ready = ($urandom_range(0, 9) < 7);
          step();
        end
        out_ready = ($urandom_range(0, 9) < 7);
        send(real'($urandom_range(0, 64)) / 4.0 - 8.0, t == len - 1, b, relu);
      end
    end
    out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
